// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control side of the mm:ss countdown timer: digit entry, run control
// and the BCD display/status returned to the display drivers.
interface bcd_countdown_timer_if #(
  parameter int MIN_DIGITS = 2
);
  logic [3:0]              digit;
  logic                    load;
  logic                    enable;
  logic                    add30;
  logic [3:0]              sec_ones;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    zero;
  logic                    done;
  logic                    running;

  modport master (
    output digit, load, enable, add30,
    input  sec_ones, sec_tens, mins, zero, done, running
  );

  modport slave (
    input  digit, load, enable, add30,
    output sec_ones, sec_tens, mins, zero, done, running
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD mm:ss countdown: keypad shift entry, +30 s quick-add,
// prescaled per-second decrement with pause that keeps the sub-second phase.
module bcd_countdown_timer #(
  parameter int MIN_DIGITS    = 2,
  parameter int TICKS_PER_SEC = 1
) (
  input  logic                 i_clock,
  input  logic                 i_clear,
  bcd_countdown_timer_if.slave io_tmr
);
  localparam int              PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   P_TERM = PW'(TICKS_PER_SEC - 1);

  logic [3:0]                 r_sec_ones;
  logic [3:0]                 r_sec_tens;
  logic [MIN_DIGITS-1:0][3:0] r_mins;
  logic [PW-1:0]              r_presc;
  logic                       r_done;

  logic                       w_zero;
  logic                       w_load;
  logic                       w_add;
  logic                       w_count;
  logic                       w_tick;

  logic [3:0]                 w_dec_ones;
  logic [3:0]                 w_dec_tens;
  logic [MIN_DIGITS-1:0][3:0] w_dec_mins;
  logic                       w_dec_zero;

  logic [3:0]                 w_add_ones;
  logic [3:0]                 w_add_tens;
  logic [MIN_DIGITS-1:0][3:0] w_add_mins;

  assign w_zero  = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) && (r_mins == '0);
  assign w_load  = io_tmr.load & ~io_tmr.enable;
  assign w_add   = ~w_load & io_tmr.add30;
  assign w_count = io_tmr.enable & ~w_zero;
  assign w_tick  = w_count && (r_presc == P_TERM);

  // BCD borrow chain; sec_tens wraps to 5, every other digit to 9.
  always_comb begin
    logic b;
    b          = 1'b0;
    w_dec_ones = r_sec_ones - 4'd1;
    if (r_sec_ones == 4'd0) begin
      w_dec_ones = 4'd9;
      b          = 1'b1;
    end
    w_dec_tens = r_sec_tens;
    if (b) begin
      if (r_sec_tens == 4'd0) begin
        w_dec_tens = 4'd5;
      end else begin
        w_dec_tens = r_sec_tens - 4'd1;
        b          = 1'b0;
      end
    end
    w_dec_mins = r_mins;
    for (int k = 0; k < MIN_DIGITS; k++) begin
      if (b) begin
        if (r_mins[k] == 4'd0) begin
          w_dec_mins[k] = 4'd9;
        end else begin
          w_dec_mins[k] = r_mins[k] - 4'd1;
          b             = 1'b0;
        end
      end
    end
  end

  assign w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_mins == '0);

  // +30 s: carry into minutes when sec_tens passes 5; overflow saturates.
  always_comb begin
    logic c;
    c          = 1'b0;
    w_add_ones = r_sec_ones;
    w_add_mins = r_mins;
    if (r_sec_tens <= 4'd2) begin
      w_add_tens = r_sec_tens + 4'd3;
    end else begin
      w_add_tens = r_sec_tens - 4'd3;
      c          = 1'b1;
    end
    for (int k = 0; k < MIN_DIGITS; k++) begin
      if (c) begin
        if (r_mins[k] == 4'd9) begin
          w_add_mins[k] = 4'd0;
        end else begin
          w_add_mins[k] = r_mins[k] + 4'd1;
          c             = 1'b0;
        end
      end
    end
    if (c) begin
      w_add_mins = {MIN_DIGITS{4'd9}};
      w_add_tens = 4'd5;
      w_add_ones = 4'd9;
    end
  end

  // An add30 on a terminal-count cycle leaves the prescaler at P_TERM, so
  // the pending tick fires on the next eligible cycle.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_mins     <= '0;
      r_presc    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_presc <= '0;
        if (io_tmr.digit <= 4'd9) begin
          r_sec_ones <= io_tmr.digit;
          r_sec_tens <= r_sec_ones;
          r_mins[0]  <= r_sec_tens;
          for (int k = 1; k < MIN_DIGITS; k++) r_mins[k] <= r_mins[k-1];
        end
      end else if (w_add) begin
        r_sec_ones <= w_add_ones;
        r_sec_tens <= w_add_tens;
        r_mins     <= w_add_mins;
      end else if (w_count) begin
        if (w_tick) begin
          r_presc    <= '0;
          r_sec_ones <= w_dec_ones;
          r_sec_tens <= w_dec_tens;
          r_mins     <= w_dec_mins;
          r_done     <= w_dec_zero;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign io_tmr.sec_ones = r_sec_ones;
  assign io_tmr.sec_tens = r_sec_tens;
  assign io_tmr.mins     = r_mins;
  assign io_tmr.zero     = w_zero;
  assign io_tmr.done     = r_done;
  assign io_tmr.running  = io_tmr.enable & ~w_zero;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: one timer at 1 tick/s, one at 4 ticks/s, both 2 minute digits.
module tb_bcd_countdown_timer;
  logic clk;
  logic clr1, clr4;
  int   total = 0;
  int   bad   = 0;

  bcd_countdown_timer_if #(.MIN_DIGITS(2)) if1 ();
  bcd_countdown_timer_if #(.MIN_DIGITS(2)) if4 ();

  bcd_countdown_timer #(.MIN_DIGITS(2), .TICKS_PER_SEC(1)) u_t1 (
    .i_clock (clk),
    .i_clear (clr1),
    .io_tmr  (if1)
  );

  bcd_countdown_timer #(.MIN_DIGITS(2), .TICKS_PER_SEC(4)) u_t4 (
    .i_clock (clk),
    .i_clear (clr4),
    .io_tmr  (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] d1();
    return {16'h0, if1.mins, if1.sec_tens, if1.sec_ones};
  endfunction

  function automatic logic [31:0] d4();
    return {16'h0, if4.mins, if4.sec_tens, if4.sec_ones};
  endfunction

  task automatic ld1(input logic [3:0] d);
    if1.load = 1'b1; if1.digit = d; step(1); if1.load = 1'b0;
  endtask

  task automatic ld4(input logic [3:0] d);
    if4.load = 1'b1; if4.digit = d; step(1); if4.load = 1'b0;
  endtask

  task automatic clear1();
    clr1 = 1'b1; step(1); clr1 = 1'b0;
  endtask

  task automatic clear4();
    clr4 = 1'b1; step(1); clr4 = 1'b0;
  endtask

  task automatic add1();
    if1.add30 = 1'b1; step(1); if1.add30 = 1'b0;
  endtask

  initial begin
    clr1 = 1'b1; clr4 = 1'b1;
    if1.digit = 4'd0; if1.load = 1'b0; if1.enable = 1'b0; if1.add30 = 1'b0;
    if4.digit = 4'd0; if4.load = 1'b0; if4.enable = 1'b0; if4.add30 = 1'b0;
    step(2);
    chk("rst_disp", d1(), 32'h0000);
    chk("rst_zero", 32'(if1.zero), 32'd1);
    chk("rst_run",  32'(if1.running), 32'd0);
    chk("rst_done", 32'(if1.done), 32'd0);
    clr1 = 1'b0; clr4 = 1'b0;

    // digit entry
    ld1(4'd2); chk("ld_2", d1(), 32'h0002);
    ld1(4'd1); chk("ld_21", d1(), 32'h0021);
    ld1(4'd9); chk("ld_219", d1(), 32'h0219);
    chk("ld_zero", 32'(if1.zero), 32'd0);
    ld1(4'hC); chk("ld_bad", d1(), 32'h0219);

    // countdown to 0:00
    if1.enable = 1'b1;
    step(1);   chk("cd_1", d1(), 32'h0218);
    step(19);  chk("cd_20", d1(), 32'h0159);
    chk("cd_run", 32'(if1.running), 32'd1);
    step(118); chk("cd_138", d1(), 32'h0001);
    chk("cd_nodone", 32'(if1.done), 32'd0);
    step(1);   chk("cd_139", d1(), 32'h0000);
    chk("cd_done", 32'(if1.done), 32'd1);
    chk("cd_zero", 32'(if1.zero), 32'd1);
    chk("cd_run0", 32'(if1.running), 32'd0);
    step(1);   chk("cd_done_off", 32'(if1.done), 32'd0);
    step(3);   chk("cd_hold", d1(), 32'h0000);
    chk("cd_done_quiet", 32'(if1.done), 32'd0);
    if1.enable = 1'b0;

    // add30 cases
    ld1(4'd4); ld1(4'd5); add1(); chk("add_045", d1(), 32'h0115);
    clear1(); chk("clr_disp", d1(), 32'h0000);
    ld1(4'd2); ld1(4'd0); add1(); chk("add_020", d1(), 32'h0050);
    clear1(); ld1(4'd9); ld1(4'd5); ld1(4'd0); add1(); chk("add_950", d1(), 32'h1020);
    clear1(); ld1(4'd9); ld1(4'd9); ld1(4'd4); ld1(4'd5);
    chk("ld_9945", d1(), 32'h9945);
    add1(); chk("add_sat", d1(), 32'h9959);
    clear1();
    if1.enable = 1'b1; if1.add30 = 1'b1; step(1); if1.add30 = 1'b0;
    chk("add_from0", d1(), 32'h0030);
    chk("add_run", 32'(if1.running), 32'd1);
    chk("add_nodone", 32'(if1.done), 32'd0);
    if1.enable = 1'b0;

    // tick coinciding with add30
    clear1(); ld1(4'd4); ld1(4'd5);
    if1.enable = 1'b1; if1.add30 = 1'b1; step(1); if1.add30 = 1'b0;
    chk("coin_add", d1(), 32'h0115);
    step(1); chk("coin_tick", d1(), 32'h0114);
    if1.enable = 1'b0;

    // clear mid-count on the 1 tick/s timer
    clear1(); ld1(4'd1); ld1(4'd0); ld1(4'd7);
    if1.enable = 1'b1; clr1 = 1'b1; step(1); clr1 = 1'b0;
    chk("mclr_disp", d1(), 32'h0000);
    chk("mclr_done", 32'(if1.done), 32'd0);
    step(2);
    chk("mclr_done2", 32'(if1.done), 32'd0);
    if1.enable = 1'b0;

    // pause/resume at 4 ticks/s
    clear4(); ld4(4'd1); ld4(4'd0); chk("p_ld", d4(), 32'h0010);
    if4.enable = 1'b1;
    step(3); chk("p_e3", d4(), 32'h0010);
    step(1); chk("p_e4", d4(), 32'h0009);
    if4.load = 1'b1; if4.digit = 4'd3;
    step(2); if4.load = 1'b0;
    chk("p_ld_ign", d4(), 32'h0009);
    if4.enable = 1'b0;
    step(30); chk("p_hold", d4(), 32'h0009);
    chk("p_run", 32'(if4.running), 32'd0);
    if4.enable = 1'b1;
    step(1); chk("p_r1", d4(), 32'h0009);
    step(1); chk("p_r2", d4(), 32'h0008);

    // clear mid-phase, prescaler must restart from 0
    if4.enable = 1'b0;
    clear4(); ld4(4'd1); ld4(4'd0); ld4(4'd7); chk("c4_ld", d4(), 32'h0107);
    if4.enable = 1'b1; step(2);
    clr4 = 1'b1; step(1); clr4 = 1'b0;
    chk("c4_clr", d4(), 32'h0000);
    chk("c4_done", 32'(if4.done), 32'd0);
    if4.enable = 1'b0;
    if4.add30 = 1'b1; step(1); if4.add30 = 1'b0;
    chk("c4_add", d4(), 32'h0030);
    if4.enable = 1'b1;
    step(3); chk("c4_e3", d4(), 32'h0030);
    step(1); chk("c4_e4", d4(), 32'h0029);
    if4.enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised successor of the microwave mm:ss countdown timer. Supports a configurable number of minute digits, a per-second prescaler, keypad digit entry via a shift register, pause/resume with preserved sub-second phase, and a "+30 s" quick-add. It sits between the keypad decoder and the 7-segment display drivers and tells the control FSM when cooking time has expired.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..4); maximum display is all-9s minutes with 59 seconds.
TICKS_PER_SEC, 1, number of clock cycles per second decrement (>=1); prescaler width is clog2(TICKS_PER_SEC), minimum 1 bit.

Ports:
clock  in  1  single system clock, rising edge.
clear  in  1  synchronous, active-high reset; clears all state.
digit  in  4  BCD keypad digit, sampled when load=1.
load  in  1  shift digit into display; honoured only while enable=0.
enable  in  1  level; 1 = count down, 0 = paused.
add30  in  1  single-cycle request to add 30 seconds.
sec_ones  out  4  BCD seconds units.
sec_tens  out  4  BCD seconds tens.
mins  out  4*MIN_DIGITS  BCD minutes; digit 0 is in bits [3:0].
zero  out  1  1 when every display digit is 0.
done  out  1  one-cycle pulse after a countdown reaches 0:00.
running  out  1  enable & ~zero.

Behaviour:
- Reset (clear=1 at an edge): all digits 0, prescaler 0, done=0. Consequently zero=1 and running=0. clear has priority over every other input.
- Priority, when clear=0: load (only if enable=0), then add30, then tick.
- Load: if digit<=9, shift left one digit. digit goes to sec_ones, sec_ones to sec_tens, sec_tens to mins[0], and mins[k] to mins[k+1]. The top minute digit is discarded. If digit>9, no change. Load also clears the prescaler. Entered sec_tens values 6..9 are not normalised; for example, 0:99 counts 99, 98, ..., 90, 89, ...
- add30:
  - If sec_tens<=2: sec_tens += 3.
  - Otherwise: sec_tens -= 3 and a minute carry is generated.
  - A minute carry is a BCD increment across the mins digits.
  - If the carry propagates out of the top digit, the whole display saturates to all-9s minutes with 5 in sec_tens and 9 in sec_ones.
  - add30 is accepted whether paused or running, and from 0:00.
  - The prescaler is untouched.
- Prescaler:
  - Increments each cycle while enable=1 and zero=0.
  - At count TICKS_PER_SEC-1 a tick occurs and the prescaler returns to 0.
  - It holds its value while enable=0, so resume keeps the sub-second phase.
  - It is cleared on clear, on load, and when the display reaches 0:00.
- Tick decrement (BCD borrow chain):
  - sec_ones 0 becomes 9 and borrows from sec_tens.
  - sec_tens 0 with a borrow becomes 5 and borrows from the minutes.
  - Each mins digit 0 with a borrow becomes 9 and borrows onward.
  - A tick is never issued while zero=1, so there is no wrap below 0:00.
- Tick coinciding with add30: add30 is applied, and the prescaler holds at its terminal count. The deferred tick then fires on the next cycle in which add30=0 and the other tick conditions hold, so no second is lost.
- done: registered. It is 1 for exactly one cycle, the cycle after the edge on which a tick turned a non-zero value into 0:00. done is never raised by clear, by load, or by power-up zero.
- zero and running are combinational from the registers; all other outputs are registered.
- Latency: load and add30 are visible one edge after sampling. The first decrement occurs TICKS_PER_SEC edges after enable rises from prescaler=0.

Test Plan:
1. Digit entry: clear, then with enable=0 and TICKS_PER_SEC=1, load 2, 1, 9 (one cycle each) -> mins=02, sec_tens=1, sec_ones=9, zero=0. Then load digit=4'hC -> display unchanged.
2. Countdown across the minute boundary: from 2:19, set enable=1 -> after 1 edge 2:18; after 20 edges 1:59. done pulses exactly once, on the cycle after the 139th edge, and the display stays 0:00 with zero=1 and running=0.
3. Pause/resume with TICKS_PER_SEC=4: enable=1 for 6 edges from 0:10 -> 0:09 with prescaler=2. Then enable=0 for 30 edges -> value held, and load pulses issued while enable=1 are ignored. Re-enable -> 0:08 after 2 more edges.
4. add30: 0:45 -> 1:15; 0:20 -> 0:50; 9:50 -> 10:20. With MIN_DIGITS=2, 99:45 -> 99:59 (saturate). From 0:00 with enable=1 -> 0:30 and running=1.
5. Simultaneous tick and add30 with TICKS_PER_SEC=1 from 0:45 -> next edge 1:15, then 1:14 on the following edge.
6. clear mid-count at 1:07 -> all digits 0 on the next edge, done stays 0, and the prescaler restarts from 0 on the next load or add30 followed by enable.
